// File: rtl/bit_counter_pkg.sv
// Shared definitions for the sequential bit counter: FSM state encoding and
// the width helper used to size counters that must hold a value up to N.
package bit_counter_pkg;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    // Bits needed to represent every value from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bit_counter_seq_chunk_popcount.sv
// Combinational popcount of one CHUNK-bit slice; the result is wide enough
// to hold the value CHUNK itself.
module chunk_popcount
    import bit_counter_pkg::*;
#(
    parameter int CHUNK = 1,
    parameter int PC_W  = cnt_width(CHUNK)
) (
    input  logic [CHUNK-1:0] i_bits,
    output logic [PC_W-1:0]  o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            o_count = o_count + PC_W'(i_bits[i]);
        end
    end

endmodule

// File: rtl/bit_counter_seq.sv
// Multi-cycle popcount: scans CHUNK bits per cycle from the LSB end and stops
// as soon as the unscanned remainder is zero, then pulses done for one cycle.
module bit_counter_seq
    import bit_counter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 1,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] data_in,
    input  logic             count_zeros,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CL_W   = cnt_width(NCHUNK);
    localparam int PC_W   = cnt_width(CHUNK);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sreg;
    logic             r_mode;
    logic [CNT_W-1:0] r_acc;
    logic [CL_W-1:0]  r_chunks_left;
    logic [CNT_W-1:0] r_count;

    logic [PC_W-1:0]  w_pc;
    logic [CNT_W-1:0] w_acc_next;
    logic [WIDTH-1:0] w_sreg_shift;
    logic             w_last;

    chunk_popcount #(
        .CHUNK (CHUNK),
        .PC_W  (PC_W)
    ) u_chunk_popcount (
        .i_bits  (r_sreg[CHUNK-1:0]),
        .o_count (w_pc)
    );

    assign w_acc_next   = r_acc + CNT_W'(w_pc);
    assign w_sreg_shift = r_sreg >> CHUNK;
    // Early exit: nothing left above the chunk just counted.
    assign w_last       = (w_sreg_shift == '0) || (r_chunks_left == CL_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_sreg        <= '0;
            r_mode        <= 1'b0;
            r_acc         <= '0;
            r_chunks_left <= '0;
            r_count       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (init) begin
                        r_sreg        <= data_in;
                        r_mode        <= count_zeros;
                        r_acc         <= '0;
                        r_chunks_left <= CL_W'(NCHUNK);
                        r_state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc         <= w_acc_next;
                    r_sreg        <= w_sreg_shift;
                    r_chunks_left <= r_chunks_left - CL_W'(1);
                    if (w_last) begin
                        r_count <= r_mode ? (CNT_W'(WIDTH) - w_acc_next) : w_acc_next;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign count = r_count;

endmodule

// File: doc/bit_counter_seq.md
Name: bit_counter_seq

Overview:
Parametrised sequential bit counter. It counts the set (or clear) bits of a WIDTH-bit word, examining CHUNK bits per clock. Control FSM and datapath (shift register, accumulator, chunk counter) are in one block. Scanning stops early once the remaining unscanned bits are all zero. The block is used wherever a multi-cycle popcount with an init/done handshake is needed.

Parameters:
WIDTH, 16, operand width in bits; must be ≥ 2.
CHUNK, 1, bits examined per RUN cycle; must divide WIDTH exactly; 1 ≤ CHUNK ≤ WIDTH.
CNT_W, $clog2(WIDTH+1), result width; must hold the value WIDTH.

Ports:
clk  in  1  clock; all state changes on posedge.
rst  in  1  reset, synchronous, active-high.
init  in  1  start request; sampled only in IDLE.
data_in  in  WIDTH  operand; captured on the accepted init edge.
count_zeros  in  1  mode: 0 = count ones, 1 = count zeros; captured with data_in.
busy  out  1  high while in RUN.
done  out  1  one-cycle pulse in DONE.
count  out  CNT_W  result register; valid from the done cycle and held until the next accepted init.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; busy=0, done=0, count=0.
  - Shift register, accumulator, chunk counter and mode register all cleared.
  - rst has priority over every other input in every state, including mid-RUN; the run is aborted and no done pulse follows.
- States: IDLE, RUN, DONE. busy and done are decoded from state: busy=(state==RUN), done=(state==DONE).
- IDLE:
  - init=1: sreg<=data_in, mode<=count_zeros, acc<=0, chunks_left<=WIDTH/CHUNK; go to RUN.
  - init=0: stay in IDLE.
  - count is not altered on entry to IDLE.
- RUN, each cycle:
  - acc_next = acc + popcount(sreg[CHUNK-1:0]).
  - sreg <= sreg >> CHUNK, zero-filled.
  - chunks_left <= chunks_left-1.
  - Go to DONE when (sreg >> CHUNK)==0 or chunks_left==1; otherwise stay in RUN.
  - On that transition: count <= mode ? WIDTH-acc_next : acc_next. acc_next is the value after this cycle's add.
- DONE: lasts exactly one cycle, then IDLE unconditionally. init asserted in DONE is ignored.
- init while busy: ignored. No restart, no queueing, operand not resampled.
- Latency:
  - k = index of the highest CHUNK-sized chunk of data_in containing a 1, plus 1; k=1 when data_in==0. Range 1 ≤ k ≤ WIDTH/CHUNK.
  - init accepted at edge n → busy high for cycles n+1 .. n+k → done high in cycle n+k+1.
  - Next init can be accepted at edge n+k+2.
- Width rules:
  - acc is CNT_W bits and never overflows, since the maximum is WIDTH.
  - WIDTH-acc is computed in CNT_W bits; the result is never negative.
- Boundaries:
  - data_in all zeros: ones mode → 0, zeros mode → WIDTH, k=1.
  - data_in all ones: ones mode → WIDTH, zeros mode → 0, k=WIDTH/CHUNK.
  - CHUNK=WIDTH: k=1 always.
  - MSB-only operand: k=WIDTH/CHUNK, exercising the full scan.
- data_in and count_zeros changing during RUN have no effect.

Decomposition:
- Shared package bit_counter_pkg holds:
  - state encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10; 2'b11 is illegal and goes to IDLE.
  - a clog2-based width helper.
- One sub-module: chunk_popcount, purely combinational.
  - Parameter CHUNK; input CHUNK bits, output $clog2(CHUNK+1) bits.
  - Instantiated once in the RUN datapath.
- Everything else stays in bit_counter_seq.

Test Plan:
1. WIDTH=16, CHUNK=1, data_in=16'h0000, count_zeros=0, init pulse at edge 0 → busy high in cycle 1 only, done in cycle 2, count=0. Repeat with count_zeros=1 → count=16.
2. WIDTH=16, CHUNK=1, data_in=16'h8001, ones mode → busy cycles 1..16, done in cycle 17, count=2. Then data_in=16'h0007 → busy cycles 1..3 (early exit), count=3.
3. WIDTH=16, CHUNK=4, data_in=16'h00F3 → k=2, done 3 cycles after init, count=6. Zeros mode → count=10. data_in=16'hFFFF → k=4, count=16 (CNT_W=5 holds it).
4. init held high continuously from cycle 0, data_in=16'h0F0F then changed to 16'hFFFF mid-RUN (CHUNK=1) → single run, count=8, done pulses once. The second run starts at the edge after DONE (IDLE accepts init), and its operand is whatever data_in is at that edge.
5. rst=1 asserted in RUN cycle 3 of an 8-cycle run → next cycle state=IDLE, busy=0, done=0, count=0, and no done pulse ever appears for the aborted run. A fresh init afterwards completes normally.
6. Randomised regression, 1000 operands, CHUNK ∈ {1,2,4,8,16}, both modes. Check count against a reference popcount, k against the highest-set-chunk formula, and that done is high exactly one cycle per accepted init.
